// File: rtl/led_sweep_counter.sv
// Parametrised LED sweep counter: bounce / wrap-up / wrap-down / hold modes
// stepped by an internal clock-enable tick, with a one-cycle reversal/wrap strobe.
module led_sweep_counter #(
    parameter int WIDTH = 5,
    parameter int DIV   = 12_000_000,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pmod,
    output logic [WIDTH-1:0] led,
    output logic             dir,
    output logic             tick,
    output logic             evt
);

    localparam int               DW       = $clog2(DIV);
    localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
    localparam logic [WIDTH:0]   MAX_X    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_LO  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] TURN_LO  = WIDTH'((1 << WIDTH) - 1 - STEP);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    logic [1:0]       sync1_q, sync1_d;
    mode_e            mode_q, mode_d;
    logic [DW-1:0]    div_q, div_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             dir_q, dir_d;
    logic             evt_q, evt_d;

    // One extra bit on every operand so carry/borrow falls out of the MSB.
    logic [WIDTH:0]   led_x, sum_x, diff_x, room_x;

    always_comb begin
        sync1_d = pmod;
        mode_d  = mode_e'(sync1_q);
        tick_d  = (div_q == DIV_LAST);
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    always_comb begin
        led_x  = {1'b0, led_q};
        sum_x  = led_x + STEP_X;
        diff_x = led_x - STEP_X;
        room_x = MAX_X - led_x;
    end

    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        evt_d = 1'b0;
        if (tick_q) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (led_x == MAX_X) begin
                            led_d = TURN_LO;
                            dir_d = 1'b0;
                            evt_d = 1'b1;
                        end else if (room_x < STEP_X) begin
                            led_d = '1;
                        end else begin
                            led_d = sum_x[WIDTH-1:0];
                        end
                    end else begin
                        if (led_x == '0) begin
                            led_d = STEP_LO;
                            dir_d = 1'b1;
                            evt_d = 1'b1;
                        end else if (led_x < STEP_X) begin
                            led_d = '0;
                        end else begin
                            led_d = diff_x[WIDTH-1:0];
                        end
                    end
                end
                MODE_WRAP_UP: begin
                    led_d = sum_x[WIDTH-1:0];
                    dir_d = 1'b1;
                    evt_d = sum_x[WIDTH];
                end
                MODE_WRAP_DOWN: begin
                    led_d = diff_x[WIDTH-1:0];
                    dir_d = 1'b0;
                    evt_d = diff_x[WIDTH];
                end
                default: begin
                    // hold: counter and direction frozen
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            mode_q  <= MODE_BOUNCE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
            dir_q   <= 1'b1;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            evt_q   <= evt_d;
        end
    end

    assign led  = led_q;
    assign dir  = dir_q;
    assign tick = tick_q;
    assign evt  = evt_q;

endmodule

// File: tb/tb_led_sweep_counter.sv
// Scoreboard bench for led_sweep_counter: two instances (STEP=1, STEP=3) against
// an arithmetic reference model, directed phases followed by random mode/reset traffic.
module tb_led_sweep_counter;

    localparam int W    = 3;
    localparam int DIV  = 4;
    localparam int MAXV = 7;

    logic         clk;
    logic         rst;
    logic [1:0]   pmod;
    logic [W-1:0] led_o  [2];
    logic         dir_o  [2];
    logic         tick_o [2];
    logic         evt_o  [2];

    led_sweep_counter #(.WIDTH(W), .DIV(DIV), .STEP(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .pmod(pmod),
        .led(led_o[0]), .dir(dir_o[0]), .tick(tick_o[0]), .evt(evt_o[0])
    );

    led_sweep_counter #(.WIDTH(W), .DIV(DIV), .STEP(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .pmod(pmod),
        .led(led_o[1]), .dir(dir_o[1]), .tick(tick_o[1]), .evt(evt_o[1])
    );

    typedef struct packed {
        logic [W-1:0] led;
        logic         dir;
        logic         tick;
        logic         evt;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks = 0;
    int   errors = 0;

    int   steps[2] = '{1, 3};
    int   m_led[2];
    int   m_dir[2];
    int   m_evt[2];
    bit   m_tick;
    int   n_edges;
    int   hist[$];

    int   exp1[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int   exp3[7]  = '{3, 6, 7, 4, 1, 0, 3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_field(input string name, input int d,
                               input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, expv, $time);
        end
    endtask

    task automatic check_dut(input int d, input exp_t e);
        check_field("led",  d, 8'(led_o[d]),  8'(e.led));
        check_field("dir",  d, 8'(dir_o[d]),  8'(e.dir));
        check_field("tick", d, 8'(tick_o[d]), 8'(e.tick));
        check_field("evt",  d, 8'(evt_o[d]),  8'(e.evt));
    endtask

    // Reference rules: bounce saturates at the ends and reflects from them,
    // wrap modes are modular arithmetic, hold changes nothing.
    task automatic model_update(input int mode, input int step,
                                input int led_in, input int dir_in,
                                output int led_out, output int dir_out, output int evt_out);
        led_out = led_in;
        dir_out = dir_in;
        evt_out = 0;
        case (mode)
            0: begin
                if (dir_in == 1) begin
                    if (led_in == MAXV) begin
                        led_out = MAXV - step; dir_out = 0; evt_out = 1;
                    end else begin
                        led_out = (led_in + step > MAXV) ? MAXV : led_in + step;
                    end
                end else begin
                    if (led_in == 0) begin
                        led_out = step; dir_out = 1; evt_out = 1;
                    end else begin
                        led_out = (led_in - step < 0) ? 0 : led_in - step;
                    end
                end
            end
            1: begin
                evt_out = (led_in + step > MAXV) ? 1 : 0;
                led_out = (led_in + step) % (MAXV + 1);
                dir_out = 1;
            end
            2: begin
                evt_out = (led_in - step < 0) ? 1 : 0;
                led_out = (led_in - step + MAXV + 1) % (MAXV + 1);
                dir_out = 0;
            end
            default: ;
        endcase
    endtask

    // Reference model: advances once per clock edge and queues the expected outputs.
    initial begin
        int   mode;
        int   nl, nd, ne;
        exp_t e;
        n_edges = 0;
        m_tick  = 1'b0;
        hist    = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 0; m_dir[d] = 1; m_evt[d] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                for (int d = 0; d < 2; d++) begin
                    m_led[d] = 0; m_dir[d] = 1; m_evt[d] = 0;
                end
                hist    = '{0, 0};
                n_edges = 0;
                m_tick  = 1'b0;
            end else begin
                mode = hist[1];
                hist.push_front(int'(pmod));
                void'(hist.pop_back());
                for (int d = 0; d < 2; d++) begin
                    if (m_tick) begin
                        model_update(mode, steps[d], m_led[d], m_dir[d], nl, nd, ne);
                        m_led[d] = nl; m_dir[d] = nd; m_evt[d] = ne;
                    end else begin
                        m_evt[d] = 0;
                    end
                end
                n_edges++;
                m_tick = ((n_edges % DIV) == 0);
            end
            e.tick = m_tick;
            e.led = W'(m_led[0]); e.dir = m_dir[0][0]; e.evt = m_evt[0][0];
            sb0.push_back(e);
            e.led = W'(m_led[1]); e.dir = m_dir[1][0]; e.evt = m_evt[1][0];
            sb1.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against queued expectations away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb0.size() > 0) check_dut(0, sb0.pop_front());
            if (sb1.size() > 0) check_dut(1, sb1.pop_front());
        end
    end

    task automatic hold_mode(input logic [1:0] m, input int cycles);
        pmod = m;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int k;
        rst  = 1'b1;
        pmod = 2'b11;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        pmod = 2'b00;

        // Bounce sequences from reset, read one cycle after each tick.
        repeat (5) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) repeat (DIV) @(negedge clk);
            check_field("bounce_step1_led", 0, 8'(led_o[0]), 8'(exp1[i]));
            if (i < 7) check_field("bounce_step3_led", 1, 8'(led_o[1]), 8'(exp3[i]));
        end

        hold_mode(2'b01, 24);
        hold_mode(2'b10, 24);
        hold_mode(2'b11, 44);
        hold_mode(2'b00, 20);

        // Reset asserted so that it lands on the edge that samples a tick.
        k = 0;
        while (!m_tick && k < 8) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!m_tick) begin
            errors++;
            $display("FAIL tick_wait: got no tick within 8 cycles, required a tick");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_mode(2'b10, 20);

        for (int it = 0; it < 300; it++) begin
            pmod = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 16)) begin
                @(negedge clk);
                rst = ($urandom_range(0, 79) == 0);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
